fetch_stage: RTL and testbench

Instruction-fetch stage and IF/EX pipeline register of the two-stage pipelined processor. Holds the program counter, drives the word address of the combinational instruction memory, and registers the fetched instruction with its PC for the execute stage. Supports pipeline stall and a branch/jump redirect that flushes the wrong-path instruction. Keeps a sticky misaligned-target flag and a fetch counter for debug display.

---
 rtl/fetch_stage_if.sv | 21 ++
 rtl/fetch_stage.sv | 86 ++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and a combinational
// instruction ROM/RAM. The fetch stage drives the word address, and the
// memory returns the addressed word in the same cycle.
interface fetch_stage_if #(
  parameter int ADDR_BITS = 8
);
  logic [ADDR_BITS-1:0] imem_addr;
  logic [31:0]          imem_data;

  // Fetch stage side: drives the address and consumes the instruction word.
  modport master (
    output imem_addr,
    input  imem_data
  );

  // Memory side: consumes the address and returns the instruction word.
  modport slave (
    input  imem_addr,
    output imem_data
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/EX pipeline register.
// Holds the PC, addresses the combinational instruction memory, and
// registers each fetched word together with its PC for the execute stage.
// A redirect flushes the wrong-path instruction and wins over a stall.
// A misaligned redirect target sets a sticky flag that only reset clears.
module fetch_stage #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          IMEM_ADDR_BITS = 8,
  parameter int          COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  fetch_stage_if.master          imem,
  output logic [31:0]            pc_out,
  output logic                   id_valid,
  output logic [31:0]            id_inst,
  output logic [31:0]            id_pc,
  output logic [31:0]            id_pc_plus4,
  output logic                   misalign_err,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  logic [31:0]            pc_r;
  logic                   id_valid_r;
  logic [31:0]            id_inst_r;
  logic [31:0]            id_pc_r;
  logic [31:0]            id_pc_plus4_r;
  logic                   misalign_err_r;
  logic [COUNT_WIDTH-1:0] fetch_count_r;
  logic [31:0]            pc_plus4_s;

  // The PC wraps naturally at 2^32, and no overflow flag is kept.
  assign pc_plus4_s = pc_r + 32'd4;

  // The word address ignores the byte offset and any PC bits above the
  // memory size, so the memory aliases across the address space.
  assign imem.imem_addr = pc_r[IMEM_ADDR_BITS+1:2];

  // PC and IF/EX register update. Priority is reset, then redirect, then
  // stall, then advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r           <= RESET_PC;
      id_valid_r     <= 1'b0;
      id_inst_r      <= 32'h0000_0000;
      id_pc_r        <= 32'h0000_0000;
      id_pc_plus4_r  <= 32'h0000_0000;
      misalign_err_r <= 1'b0;
      fetch_count_r  <= '0;
    end else if (redirect) begin
      // Insert a bubble. The target is force-aligned, and a non-zero
      // offset is only recorded in the sticky flag.
      pc_r          <= {redirect_pc[31:2], 2'b00};
      id_valid_r    <= 1'b0;
      id_inst_r     <= 32'h0000_0000;
      id_pc_r       <= 32'h0000_0000;
      id_pc_plus4_r <= 32'h0000_0000;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_err_r <= 1'b1;
      end else begin
        misalign_err_r <= misalign_err_r;
      end
    end else if (stall) begin
      pc_r <= pc_r;
    end else begin
      pc_r          <= pc_plus4_s;
      id_valid_r    <= 1'b1;
      id_inst_r     <= imem.imem_data;
      id_pc_r       <= pc_r;
      id_pc_plus4_r <= pc_plus4_s;
      fetch_count_r <= fetch_count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign pc_out       = pc_r;
  assign id_valid     = id_valid_r;
  assign id_inst      = id_inst_r;
  assign id_pc        = id_pc_r;
  assign id_pc_plus4  = id_pc_plus4_r;
  assign misalign_err = misalign_err_r;
  assign fetch_count  = fetch_count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Memory word i holds 32'h1000_0000 + i.
// A second instance with a 4-bit counter shares the same stimulus so the
// counter wrap can be observed.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic [31:0] pc_out, id_inst, id_pc, id_pc_plus4;
  logic        id_valid, misalign_err;
  logic [15:0] fetch_count;

  logic [31:0] b_pc_out, b_id_inst, b_id_pc, b_id_pc_plus4;
  logic        b_id_valid, b_misalign_err;
  logic [3:0]  b_fetch_count;

  int total;
  int bad;

  fetch_stage_if #(.ADDR_BITS(8)) imem_a ();
  fetch_stage_if #(.ADDR_BITS(8)) imem_b ();

  assign imem_a.imem_data = 32'h1000_0000 | {24'h00_0000, imem_a.imem_addr};
  assign imem_b.imem_data = 32'h1000_0000 | {24'h00_0000, imem_b.imem_addr};

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_BITS(8), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(imem_a), .pc_out(pc_out),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_BITS(8), .COUNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(imem_b), .pc_out(b_pc_out),
    .id_valid(b_id_valid), .id_inst(b_id_inst), .id_pc(b_id_pc),
    .id_pc_plus4(b_id_pc_plus4), .misalign_err(b_misalign_err),
    .fetch_count(b_fetch_count)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check every IF/EX output of the main instance.
  task automatic chk_ifex(input string tag, input logic v, input logic [31:0] inst,
                          input logic [31:0] pc, input logic [31:0] pc4);
    chk({tag, ".valid"}, {31'd0, id_valid}, {31'd0, v});
    chk({tag, ".inst"},  id_inst, inst);
    chk({tag, ".pc"},    id_pc, pc);
    chk({tag, ".pc4"},   id_pc_plus4, pc4);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0000_0000;

    // Reset state.
    tick();
    reset = 1'b0;
    chk("rst.pc", pc_out, 32'h0000_0000);
    chk_ifex("rst", 1'b0, 32'h0, 32'h0, 32'h0);
    chk("rst.mis", {31'd0, misalign_err}, 32'd0);
    chk("rst.cnt", {16'd0, fetch_count}, 32'd0);
    chk("rst.addr", {24'd0, imem_a.imem_addr}, 32'd0);

    // Free run: two fetches bring pc_out to 8.
    tick();
    chk_ifex("run0", 1'b1, 32'h1000_0000, 32'h0, 32'h4);
    chk("run0.cnt", {16'd0, fetch_count}, 32'd1);
    tick();
    chk_ifex("run1", 1'b1, 32'h1000_0001, 32'h4, 32'h8);
    chk("run1.cnt", {16'd0, fetch_count}, 32'd2);
    chk("run1.pc", pc_out, 32'h8);

    // Stall three edges at pc_out=8: everything holds.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.pc", pc_out, 32'h8);
      chk("stall.inst", id_inst, 32'h1000_0001);
      chk("stall.idpc", id_pc, 32'h4);
      chk("stall.cnt", {16'd0, fetch_count}, 32'd2);
      chk("stall.addr", {24'd0, imem_a.imem_addr}, 32'd2);
    end
    stall = 1'b0;
    tick();
    chk_ifex("resume", 1'b1, 32'h1000_0002, 32'h8, 32'hC);
    chk("resume.cnt", {16'd0, fetch_count}, 32'd3);
    chk("resume.pc", pc_out, 32'hC);

    // Redirect to 0x40 from pc_out=12: one bubble, then word 16.
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    chk("redir.pc", pc_out, 32'h40);
    chk_ifex("redir", 1'b0, 32'h0, 32'h0, 32'h0);
    chk("redir.cnt", {16'd0, fetch_count}, 32'd3);
    tick();
    chk_ifex("tgt", 1'b1, 32'h1000_0010, 32'h40, 32'h44);
    chk("tgt.cnt", {16'd0, fetch_count}, 32'd4);

    // Misaligned redirect together with stall: redirect wins, flag sets.
    redirect = 1'b1;
    redirect_pc = 32'h0000_0042;
    stall = 1'b1;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    chk("mis.pc", pc_out, 32'h40);
    chk("mis.flag", {31'd0, misalign_err}, 32'd1);
    chk("mis.valid", {31'd0, id_valid}, 32'd0);
    chk("mis.cnt", {16'd0, fetch_count}, 32'd4);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mis.sticky", {31'd0, misalign_err}, 32'd1);
    end
    chk("mis.run.pc", pc_out, 32'h68);
    chk("mis.run.cnt", {16'd0, fetch_count}, 32'd14);

    // Aliasing: 0x404 maps to word 1; aligned redirect keeps the flag.
    redirect = 1'b1;
    redirect_pc = 32'h0000_0404;
    tick();
    redirect = 1'b0;
    chk("alias.pc", pc_out, 32'h404);
    chk("alias.addr", {24'd0, imem_a.imem_addr}, 32'd1);
    chk("alias.flag", {31'd0, misalign_err}, 32'd1);
    tick();
    chk_ifex("alias.f", 1'b1, 32'h1000_0001, 32'h404, 32'h408);

    // PC wrap from the top of the address space.
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("wrap.pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap.addr", {24'd0, imem_a.imem_addr}, 32'hFF);
    tick();
    chk("wrap.pc0", pc_out, 32'h0);
    chk_ifex("wrap.f", 1'b1, 32'h1000_00FF, 32'hFFFF_FFFC, 32'h0);
    // Sixteen advances since reset: the 16-bit counter reads 16, the 4-bit one wraps to 0.
    chk("cnt16", {16'd0, fetch_count}, 32'd16);
    chk("cnt4.wrap", {28'd0, b_fetch_count}, 32'd0);
    chk("b.pc", b_pc_out, 32'h0);
    chk("b.inst", b_id_inst, 32'h1000_00FF);

    // Reset mid-run with redirect and stall asserted: reset wins.
    reset = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0042;
    stall = 1'b1;
    tick();
    reset = 1'b0;
    redirect = 1'b0;
    stall = 1'b0;
    chk("mrst.pc", pc_out, 32'h0);
    chk_ifex("mrst", 1'b0, 32'h0, 32'h0, 32'h0);
    chk("mrst.mis", {31'd0, misalign_err}, 32'd0);
    chk("mrst.cnt", {16'd0, fetch_count}, 32'd0);
    chk("mrst.cnt4", {28'd0, b_fetch_count}, 32'd0);
    tick();
    chk_ifex("mrst.f", 1'b1, 32'h1000_0000, 32'h0, 32'h4);
    chk("mrst.f.cnt", {16'd0, fetch_count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
